// File: rtl/leds_seq_pkg.sv
// leds_sequencer shared types: FSM encoding,
// pattern modes and their initial LED values.
package leds_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [1:0] BIN   = 2'd0;
  localparam logic [1:0] ROT   = 2'd1;
  localparam logic [1:0] PING  = 2'd2;
  localparam logic [1:0] BLINK = 2'd3;

  localparam logic [4:0] INIT_BIN   = 5'b00000;
  localparam logic [4:0] INIT_ROT   = 5'b00001;
  localparam logic [4:0] INIT_PING  = 5'b00001;
  localparam logic [4:0] INIT_BLINK = 5'b11111;

  function automatic logic [4:0] init_pat(
    input logic [1:0] m
  );
    logic [4:0] p;
    p = INIT_BIN;
    unique case (m)
      BIN:     p = INIT_BIN;
      ROT:     p = INIT_ROT;
      PING:    p = INIT_PING;
      BLINK:   p = INIT_BLINK;
      default: p = INIT_BIN;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/leds_sequencer_prescaler.sv
// Free-running N-bit prescaler with hold and clear;
// wrap flags the enabled terminal count.
module prescaler #(
  parameter int N = 22
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  logic [N-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign wrap = en && (cnt == {N{1'b1}});

endmodule

// File: rtl/leds_sequencer.sv
// Five-LED pattern sequencer: start/pause/stop FSM
// stepping one of four patterns per prescaler wrap.
module leds_sequencer
  import leds_seq_pkg::*;
#(
  parameter int N = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] mode,
  output logic [4:0] leds,
  output logic       busy,
  output logic       tick
);

  state_t     state_q, state_d;
  logic [4:0] leds_d;
  logic [1:0] mode_q, mode_d;
  logic       dir_q, dir_d;
  logic       busy_d, tick_d;
  logic       en, clr, wrap;

  prescaler #(.N(N)) u_pre (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (clr),
    .wrap (wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      leds    <= '0;
      mode_q  <= BIN;
      dir_q   <= 1'b1;
      busy    <= 1'b0;
      tick    <= 1'b0;
    end else begin
      state_q <= state_d;
      leds    <= leds_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      busy    <= busy_d;
      tick    <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    leds_d  = leds;
    mode_d  = mode_q;
    dir_d   = dir_q;
    tick_d  = 1'b0;
    en      = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        clr    = 1'b1;
        leds_d = '0;
        if (start && !stop) begin
          state_d = RUN;
          mode_d  = mode;
          leds_d  = init_pat(mode);
          dir_d   = 1'b1;
        end
      end
      RUN: begin
        // stop freezes the prescaler even on its wrap edge
        if (stop) begin
          state_d = PAUSE;
        end else begin
          en = 1'b1;
          if (wrap) begin
            tick_d = 1'b1;
            unique case (mode_q)
              BIN:  leds_d = leds + 5'd1;
              ROT:  leds_d = {leds[3:0], leds[4]};
              PING: begin
                if (dir_q) begin
                  if (leds[4]) begin
                    leds_d = leds >> 1;
                    dir_d  = 1'b0;
                  end else begin
                    leds_d = leds << 1;
                  end
                end else begin
                  if (leds[0]) begin
                    leds_d = leds << 1;
                    dir_d  = 1'b1;
                  end else begin
                    leds_d = leds >> 1;
                  end
                end
              end
              BLINK:   leds_d = ~leds;
              default: leds_d = leds;
            endcase
          end
        end
      end
      PAUSE: begin
        if (stop) begin
          state_d = IDLE;
          leds_d  = '0;
          clr     = 1'b1;
          dir_d   = 1'b1;
        end else if (start) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        leds_d  = '0;
        clr     = 1'b1;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

endmodule

// File: doc/leds_sequencer.md
# leds_sequencer

Pattern controller for the board's five LEDs. It owns a free-running prescaler counter and sequences it through start, pause and stop. On every prescaler wrap it advances one of four LED patterns. It sits between the user inputs (buttons or debounced pulses) and the `leds` pins, replacing a direct tap of counter MSBs with a controlled, mode-selectable sequence.

## Interface
Parameters:
- `N`, default 22: prescaler width in bits; one pattern step every 2^N clock cycles (about 0.35 s at 12 MHz).

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle pulse; starts from IDLE or resumes from PAUSE.
- `stop`  in  1: one-cycle pulse; pauses from RUN or clears from PAUSE.
- `mode`  in  2: pattern select; sampled only on the IDLE->RUN transition.
- `leds`  out  5: current pattern, registered.
- `busy`  out  1: high in RUN or PAUSE, registered.
- `tick`  out  1: one-cycle pulse, high in the cycle after each pattern step.

## Operation
- FSM states are IDLE, RUN and PAUSE. Reset value: IDLE.
- IDLE:
  - `leds`=0, prescaler held at 0, `busy`=0.
  - `start` -> RUN. On this transition latch `mode`, load the initial pattern and clear the prescaler.
  - `stop` is ignored.
- RUN:
  - Prescaler increments every cycle.
  - On wrap (2^N-1 -> 0), the pattern advances one step and `tick` pulses.
  - `stop` -> PAUSE.
  - `start` is ignored.
- PAUSE:
  - Prescaler and pattern are frozen; `leds` holds its value.
  - `start` -> RUN, resuming from the frozen prescaler value; this is not a restart.
  - `stop` -> IDLE: clear `leds`, the prescaler and the direction flag.
- `start` and `stop` in the same cycle: `stop` wins in every state.
- Patterns (latched mode):
  - 0, binary count: initial 00000; +1 per step, 11111 -> 00000 wraps (modulo 32).
  - 1, rotate: initial 00001; shift left per step, 10000 -> 00001.
  - 2, ping-pong: initial 00001 with direction up. Shift left until 10000, then right until 00001, then repeat. The end positions are shown once per pass, not doubled: ...01000, 10000, 01000...
  - 3, blink: initial 11111; toggles 11111 <-> 00000 per step.
- A change on `mode` during RUN or PAUSE has no effect until the next start from IDLE.

## Timing
- Reset values: `leds`=0, `busy`=0, `tick`=0; state IDLE, prescaler 0, direction up, latched mode 0.
- `rst` acts asynchronously on assertion. All state is cleared immediately, including mid-RUN.
- Start edge (the edge where `start`=1 is sampled in IDLE):
  - RUN, `busy`=1 and the initial pattern are visible right after that edge.
  - The first pattern step occurs 2^N edges later.
- `tick` is registered and high for exactly one cycle, coincident with the new `leds` value. It is never asserted outside RUN.
- Timing across a pause:
  - If `stop` is sampled on the same edge the prescaler would wrap, the pause wins: no step, no tick, prescaler frozen at 2^N-1.
  - On resume, the step occurs one edge after the resume edge.
  - In general, the remaining cycles to the next step are preserved across PAUSE.
- Latency from any input pulse to an output change: one edge.

## Structure
- Package `leds_seq_pkg` holds:
  - the state encoding (IDLE, RUN, PAUSE);
  - mode constants (BIN, ROT, PING, BLINK);
  - initial-pattern constants per mode.
- Sub-module `prescaler #(N)` has inputs `clk`, `rst`, `en`, `clr` and output `wrap`. `wrap` is a combinational flag meaning count == 2^N-1 and `en`.
- The pattern step logic stays in `leds_sequencer`.

## Test plan
All scenarios use N=3, giving a step every 8 cycles.
- Mode 0: `start` -> `leds`=00000, then 00001, 00010, ... after 8, 16, ... cycles. After 32 steps `leds` returns to 00000, with one `tick` per step.
- Mode 2: run 10 steps -> sequence 00010, 00100, 01000, 10000, 01000, 00100, 00010, 00001, 00010, 00100.
- Mode 1: `stop` 3 cycles into a step period -> `leds` and `busy` hold for 20 cycles with no `tick`. `start` -> next step exactly 5 cycles later. A second `stop` in PAUSE -> `leds`=0, `busy`=0.
- Simultaneous events:
  - `start`+`stop` together in IDLE -> stays IDLE.
  - Together in RUN -> PAUSE.
  - `stop` on the wrap edge -> no step, and the step fires 1 cycle after resume.
- Mode 3: `start`, then change `mode` to 0 mid-RUN -> keeps blinking 11111/00000. Assert `rst` asynchronously mid-cycle -> `leds`=0, `busy`=0, `tick`=0 before the next edge.
